// File: rtl/any1_vmem_seq_if.sv
// Element handshake between the vector memory sequencer and the address generator / memory unit.
// The master drives the element index and request; the slave answers with ack/err.
interface any1_vmem_seq_if #(
  parameter int STEPW = 6
) ();
  logic [STEPW-1:0] step;
  logic             mem_req;
  logic             mem_ack;
  logic             mem_err;
  logic             elem_done;
  logic [STEPW-1:0] elem;

  modport master (
    output step, mem_req, elem_done, elem,
    input  mem_ack, mem_err
  );

  modport slave (
    input  step, mem_req, elem_done, elem,
    output mem_ack, mem_err
  );
endinterface

// File: rtl/any1_vmem_seq.sv
// Element sequencer for strided/indexed/compressed vector memory ops: walks the active
// elements, presents each index to the address generator and handshakes it with memory.
module any1_vmem_seq #(
  parameter int VLMAX = 64,
  parameter int STEPW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_vec,
  input  logic [STEPW:0]   vl,
  input  logic             mask_en,
  input  logic [VLMAX-1:0] vmask,
  input  logic             flush,
  any1_vmem_seq_if.master  mem,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [STEPW-1:0] fault_elem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AGEN = 2'd1,
    REQ  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [STEPW-1:0] step_q, step_d;
  logic [VLMAX-1:0] act_q, act_d;
  logic             fault_q, fault_d;
  logic [STEPW-1:0] fault_elem_q, fault_elem_d;

  logic [STEPW:0]   vl_eff;
  logic [VLMAX-1:0] start_act;
  logic             first_found;
  logic [STEPW-1:0] first_idx;
  logic             next_found;
  logic [STEPW-1:0] next_idx;

  // Active set is latched as one bitmap (length and mask folded together) so the
  // priority encoders only ever search a single vector.
  always_comb begin
    vl_eff    = '0;
    start_act = '0;
    if (is_vec) begin
      vl_eff = (vl > (STEPW+1)'(VLMAX)) ? (STEPW+1)'(VLMAX) : vl;
    end else begin
      vl_eff = (STEPW+1)'(1);
    end
    for (int i = 0; i < VLMAX; i++) begin
      start_act[i] = (i < int'(vl_eff)) && (!(is_vec && mask_en) || vmask[i]);
    end
  end

  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = VLMAX-1; i >= 0; i--) begin
      if (start_act[i]) begin
        first_found = 1'b1;
        first_idx   = STEPW'(i);
      end
      if (act_q[i] && (i > int'(step_q))) begin
        next_found = 1'b1;
        next_idx   = STEPW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    act_d        = act_q;
    fault_d      = fault_q;
    fault_elem_d = fault_elem_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            act_d        = start_act;
            fault_d      = 1'b0;
            fault_elem_d = '0;
            if (first_found) begin
              step_d  = first_idx;
              state_d = AGEN;
            end else begin
              state_d = FIN;
            end
          end
        end
        AGEN: state_d = REQ;
        REQ: begin
          if (mem.mem_ack) begin
            if (mem.mem_err) begin
              fault_d      = 1'b1;
              fault_elem_d = step_q;
              state_d      = FIN;
            end else if (next_found) begin
              step_d  = next_idx;
              state_d = AGEN;
            end else begin
              state_d = FIN;
            end
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      step_q       <= '0;
      act_q        <= '0;
      fault_q      <= 1'b0;
      fault_elem_q <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      act_q        <= act_d;
      fault_q      <= fault_d;
      fault_elem_q <= fault_elem_d;
    end
  end

  // Handshake outputs are gated by flush so an aborted cycle never reports completion.
  assign busy          = (state_q != IDLE);
  assign mem.step      = step_q;
  assign mem.elem      = step_q;
  assign mem.mem_req   = (state_q == REQ) && !flush;
  assign mem.elem_done = (state_q == REQ) && mem.mem_ack && !mem.mem_err && !flush;
  assign done          = (state_q == FIN) && !flush;
  assign fault         = done && fault_q;
  assign fault_elem    = fault_elem_q;

endmodule

// File: doc/any1_vmem_seq.md
Name: any1_vmem_seq

Overview:
- Element sequencer for vector strided, indexed and compressed-vector memory operations.
- Drives the `step` input of the address generator, which registers `ea` one cycle later, then handshakes each element's access with the memory unit.
- Skips masked-off elements, stops on memory fault and reports completion to issue logic.
- Scalar memory ops pass through as a single-element sequence.

Parameters:
- VLMAX, 64, maximum vector length; also the width of the mask.
- STEPW, 6, width of the step/element index, log2(VLMAX).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begin sequence (sampled in IDLE only)
- is_vec  in  1  1 = vector op (use vl/mask), 0 = scalar (single element 0)
- vl  in  STEPW+1  vector length, 0..VLMAX; values >VLMAX clamp to VLMAX
- mask_en  in  1  1 = apply vmask
- vmask  in  VLMAX  element enable bits
- flush  in  1  abort; synchronous, highest priority
- mem_ack  in  1  memory unit completes current request
- mem_err  in  1  qualifies mem_ack; access faulted
- busy  out  1  state != IDLE
- step  out  STEPW  element index presented to the address generator
- mem_req  out  1  ea valid, request memory access
- elem_done  out  1  one-cycle pulse per element completed without error
- elem  out  STEPW  index of completed/faulting element
- done  out  1  one-cycle pulse at end of sequence
- fault  out  1  valid with done; sequence ended on mem_err
- fault_elem  out  STEPW  faulting element index, held until next start

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0; step=0, fault_elem=0.
- Latched at start: vl_r = is_vec ? min(vl,VLMAX) : 1; mask_r = (is_vec & mask_en) ? vmask : all-ones.
- Active set: elements i < vl_r with mask_r[i]=1.
- next(i): lowest active index > i, found by a combinational priority encoder; first() is the lowest active index >= 0.
- States:
  - IDLE: on start, if the active set is empty (vl_r=0 or mask zero), go to FIN with fault=0 and no memory traffic. Otherwise load step=first(), clear fault, and go to AGEN.
  - AGEN: exactly one cycle; the address generator samples step. Go to REQ.
  - REQ: mem_req=1, step and elem held stable, until mem_ack.
    - On mem_ack with mem_err=1: elem=step, fault_elem=step, fault=1; go to FIN.
    - On mem_ack with mem_err=0: elem_done=1, elem=step. If next(step) exists, step<=next and go to AGEN; else go to FIN.
  - FIN: done=1 for one cycle, fault valid alongside; go to IDLE.
- mem_req drops the cycle after mem_ack. Ack in the same cycle as REQ entry is legal, so the minimum is 2 cycles per element.
- Latency: start → first mem_req is 2 cycles (IDLE→AGEN→REQ). Last ack → done is 1 cycle.
- start while busy: ignored.
- flush: from any state go to IDLE next cycle. mem_req, elem_done and done are deasserted and no done is issued; the memory unit cancels any outstanding request. flush has priority over a simultaneous mem_ack and over start.
- mem_ack outside REQ: ignored.
- Index wrap: step never exceeds vl_r-1. An element at index VLMAX-1 ends the sequence; no wrap to 0.
- Inputs vl, vmask and is_vec are not re-sampled after start.

Test Plan:
- Scalar op: start, is_vec=0, ack on first REQ cycle → mem_req at cycle 2 with step=0, elem_done elem=0, done at cycle 3, fault=0.
- Strided vector, vl=4, mask_en=0, ack delayed 1 cycle each → steps 0,1,2,3 in order; 4 elem_done pulses; done one cycle after 4th ack; 12 cycles total.
- Masked: vl=8, vmask=0b1010_0100 → REQ only for elements 2,5,7; done after element 7.
- Empty: vl=0, or vmask=0 with mask_en=1 → no mem_req; done at cycle 1; busy high for 1 cycle.
- Fault: vl=6, mem_err on element 3 → elem_done for 0,1,2 only; done with fault=1, fault_elem=3; no REQ for 4,5.
- Flush mid-REQ on element 1 of vl=4, with mem_ack asserted the same cycle → IDLE next cycle, no elem_done for 1, no done. A following start with vl=2 sequences 0,1 normally. Async rst=0 mid-AGEN → all outputs 0 immediately.
